// File: rtl/theta_stage.sv
// Keccak theta step over a block of LINES 25-bit slices: buffer the block with per-slice column
// parities, then emit each slice mixed with its neighbours' parities. THETA_BYPASS_EN adds bypass_i.
module theta_stage #(
  parameter int unsigned LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [24:0] in_line_i,
`ifdef THETA_BYPASS_EN
  input  logic        bypass_i,
`endif
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [24:0] out_line_o,
  output logic        out_last_o,
  output logic        busy_o
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam logic [IdxW-1:0] IdxOne = IdxW'(1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(LINES - 1);

  typedef enum logic {StLoad, StEmit} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic [IdxW-1:0] rd_prev;
  logic [24:0]     buf_q [LINES];
  logic [4:0]      par_q [LINES];
  logic            in_hs;
  logic [4:0]      in_par;
  logic [4:0]      par_cur, par_prev;
  logic [4:0]      d_col;
  logic            bypass_act;

  always_comb begin
    for (int x = 0; x < 5; x++) begin
      in_par[x] = in_line_i[x] ^ in_line_i[x+5] ^ in_line_i[x+10] ^ in_line_i[x+15] ^
                  in_line_i[x+20];
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      StLoad: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          wr_idx_d = wr_idx_q + IdxOne;
          if (wr_idx_q == IdxLast) begin
            state_d  = StEmit;
            rd_idx_d = '0;
          end
        end
      end
      StEmit: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          rd_idx_d = rd_idx_q + IdxOne;
          if (rd_idx_q == IdxLast) begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StLoad;
    endcase
    // Outputs are forced quiet while reset is held.
    if (rst) begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
    end
  end

  assign in_hs = in_valid_i & in_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StLoad;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Buffer and parity store need no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      buf_q[wr_idx_q] <= in_line_i;
      par_q[wr_idx_q] <= in_par;
    end
  end

`ifdef THETA_BYPASS_EN
  logic bypass_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bypass_q <= 1'b0;
    end else if (in_hs && (wr_idx_q == '0)) begin
      bypass_q <= bypass_i;
    end
  end

  assign bypass_act = bypass_q;
`else
  assign bypass_act = 1'b0;
`endif

  // Slice z-1 wraps through the natural overflow of the index width.
  assign rd_prev  = rd_idx_q - IdxOne;
  assign par_cur  = par_q[rd_idx_q];
  assign par_prev = par_q[rd_prev];

  always_comb begin
    d_col = '0;
    if (!bypass_act) begin
      for (int x = 0; x < 5; x++) begin
        d_col[x] = par_cur[(x + 4) % 5] ^ par_prev[(x + 1) % 5];
      end
    end
  end

  assign out_line_o = out_valid_o ? (buf_q[rd_idx_q] ^ {5{d_col}}) : '0;
  assign out_last_o = out_valid_o && (rd_idx_q == IdxLast);
  assign busy_o     = !rst && !((state_q == StLoad) && (wr_idx_q == '0));

endmodule

// File: tb/tb_theta_stage.sv
// Randomized self-checking bench for theta_stage against an array-based theta reference.
// Define THETA_BYPASS_EN to also exercise the bypass block.
module tb_theta_stage;

  localparam int unsigned LINES = 64;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_line;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_line;
  logic        out_last;
  logic        busy;
`ifdef THETA_BYPASS_EN
  logic        bypass;
`endif

  int checks   = 0;
  int failures = 0;

  logic [24:0] blk      [LINES];
  logic [24:0] exp_line [LINES];

  theta_stage #(
    .LINES(LINES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_line_i  (in_line),
`ifdef THETA_BYPASS_EN
    .bypass_i   (bypass),
`endif
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_line_o (out_line),
    .out_last_o (out_last),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Theta from first principles: column parities per slice, then each bit picks up
  // the parity of column x-1 in its own slice and column x+1 in slice z-1.
  function automatic void theta_ref();
    logic [4:0] c [LINES];
    for (int z = 0; z < LINES; z++) begin
      for (int x = 0; x < 5; x++) begin
        c[z][x] = 1'b0;
        for (int y = 0; y < 5; y++) c[z][x] = c[z][x] ^ blk[z][5*y+x];
      end
    end
    for (int z = 0; z < LINES; z++) begin
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < 5; x++) begin
          exp_line[z][5*y+x] = blk[z][5*y+x] ^ c[z][(x+4)%5] ^ c[(z+LINES-1)%LINES][(x+1)%5];
        end
      end
    end
  endfunction

  function automatic void clear_block();
    for (int z = 0; z < LINES; z++) begin
      blk[z]      = '0;
      exp_line[z] = '0;
    end
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_line   = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_line", out_line, 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);
    check_eq("post_rst_busy", busy, 0);
  endtask

  task automatic send_block(input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < LINES && guard < 4000) begin
      @(negedge clk);
      guard++;
      in_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      in_line  = blk[i];
      if (in_valid && in_ready) i++;
    end
    check_eq("send_count", i, LINES);
  endtask

  task automatic recv_block(input bit rand_ready, input int stall_z, input int rst_z);
    int  n = 0;
    int  guard = 0;
    int  stall = 0;
    bit  first = 1'b1;
    bit  aborted = 1'b0;
    while (n < LINES && guard < 4000) begin
      @(negedge clk);
      guard++;
      // Traffic on the input side during EMIT must be ignored.
      in_valid = 1'($urandom_range(1));
      in_line  = 25'($urandom);
      if (first) begin
        check_eq("latency_valid", out_valid, 1);
        first = 1'b0;
      end
      if (n == rst_z) begin
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out_line", out_line, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("after_rst_in_ready", in_ready, 1);
        check_eq("after_rst_out_valid", out_valid, 0);
        check_eq("after_rst_busy", busy, 0);
        aborted = 1'b1;
        break;
      end
      check_eq("emit_valid", out_valid, 1);
      check_eq("emit_busy", busy, 1);
      check_eq($sformatf("line_z%0d", n), out_line, exp_line[n]);
      check_eq($sformatf("last_z%0d", n), out_last, (n == LINES - 1));
      if (n == stall_z && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      end
      if (out_valid && out_ready) n++;
    end
    if (!aborted) begin
      check_eq("out_count", n, LINES);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check_eq("done_in_ready", in_ready, 1);
      check_eq("done_out_valid", out_valid, 0);
      check_eq("done_busy", busy, 0);
    end
  endtask

  task automatic run_block(input bit gaps, input bit rand_ready, input int stall_z,
                           input int rst_z);
    send_block(gaps);
    recv_block(rand_ready, stall_z, rst_z);
  endtask

  initial begin
`ifdef THETA_BYPASS_EN
    bypass = 1'b0;
`endif
    do_reset();

    // All-zero block.
    clear_block();
    run_block(1'b0, 1'b0, -1, -1);

    // Single bit in slice 0.
    clear_block();
    blk[0]      = 25'h0000001;
    exp_line[0] = 25'h0210843;
    exp_line[1] = 25'h1084210;
    run_block(1'b0, 1'b0, -1, -1);

    // Single bit in the last slice: mixing wraps into slice 0.
    clear_block();
    blk[63]      = 25'h0000001;
    exp_line[63] = 25'h0210843;
    exp_line[0]  = 25'h1084210;
    run_block(1'b1, 1'b0, -1, -1);

    // Even column parity leaves everything untouched.
    clear_block();
    blk[5]      = 25'h0000021;
    exp_line[5] = 25'h0000021;
    run_block(1'b0, 1'b0, -1, -1);

    // Random block with a 3-cycle stall at slice 10.
    for (int z = 0; z < LINES; z++) blk[z] = 25'($urandom);
    theta_ref();
    run_block(1'b1, 1'b0, 10, -1);

    // Reset mid-EMIT, then a fresh single-bit block.
    for (int z = 0; z < LINES; z++) blk[z] = 25'($urandom);
    theta_ref();
    run_block(1'b0, 1'b0, -1, 20);
    clear_block();
    blk[0]      = 25'h0000001;
    exp_line[0] = 25'h0210843;
    exp_line[1] = 25'h1084210;
    run_block(1'b0, 1'b0, -1, -1);

    // Random blocks with random handshake gaps on both sides.
    for (int b = 0; b < 4; b++) begin
      for (int z = 0; z < LINES; z++) blk[z] = 25'($urandom);
      theta_ref();
      run_block(1'b1, 1'b1, -1, -1);
    end

`ifdef THETA_BYPASS_EN
    for (int z = 0; z < LINES; z++) begin
      blk[z]      = 25'($urandom);
      exp_line[z] = blk[z];
    end
    bypass = 1'b1;
    send_block(1'b1);
    bypass = 1'b0;
    recv_block(1'b1, -1, -1);
    for (int z = 0; z < LINES; z++) blk[z] = 25'($urandom);
    theta_ref();
    run_block(1'b1, 1'b1, -1, -1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/theta_stage.md
THETA_STAGE -- requirements
Module: theta_stage

Interface
REQ-001 Parameter LINES, default 64, SHALL set the number of 25-bit slices per block (power of two, 2..64).
REQ-002 clk  input  1  clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream slice valid.
REQ-005 in_ready  output  1  block accepts a slice this cycle.
REQ-006 in_line  input  25  slice z; bit i = cell (x=i%5, y=i/5).
REQ-007 out_valid  output  1  out_line holds a valid mixed slice.
REQ-008 out_ready  input  1  downstream (pi swap stage) accepts the slice.
REQ-009 out_line  output  25  theta-mixed slice, same bit mapping as in_line.
REQ-010 out_last  output  1  high with the final slice (index LINES-1) of a block.
REQ-011 busy  output  1  high in any state other than LOAD with wr_idx=0.

Function
REQ-012 The FSM SHALL have two states: LOAD (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-013 In LOAD, each in_valid&in_ready handshake SHALL write in_line to buf[wr_idx], store the 5-bit column parity C[wr_idx][x] = XOR over y of in_line[5y+x], and increment wr_idx.
REQ-014 The handshake accepting slice LINES-1 SHALL move the FSM to EMIT next cycle with rd_idx=0, wr_idx=0; out_valid SHALL assert on the cycle after the last input handshake (1-cycle latency).
REQ-015 In EMIT, out_line SHALL equal buf[rd_idx] XOR {5{D}}, where D[x] = C[rd_idx][(x+4)%5] XOR C[(rd_idx+LINES-1)%LINES][(x+1)%5].
REQ-016 z-1 SHALL wrap: slice 0 uses the parity of slice LINES-1; x±1 SHALL wrap modulo 5.
REQ-017 An out_valid&out_ready handshake SHALL increment rd_idx; with out_ready=0, out_line, out_last and rd_idx SHALL hold.
REQ-018 out_last SHALL be 1 only in EMIT with rd_idx=LINES-1.
REQ-019 The handshake with out_last=1 SHALL return the FSM to LOAD next cycle; in_ready SHALL be 1 that cycle (no pipelined overlap of blocks).
REQ-020 in_valid in EMIT SHALL be ignored; in_line SHALL not be sampled.
REQ-021 Index counters SHALL be log2(LINES) bits and wrap naturally; no arithmetic beyond XOR on data.

Reset
REQ-022 rst=1 SHALL force, next edge: state=LOAD, wr_idx=0, rd_idx=0.
REQ-023 While rst=1, in_ready, out_valid, out_last and busy SHALL be 0; out_line SHALL be 0.
REQ-024 Reset mid-LOAD or mid-EMIT SHALL discard the partial block; buf/parity contents need not be cleared (overwritten before use).

Configuration
REQ-025 Macro THETA_BYPASS_EN, when defined, SHALL add input bypass (1 bit); with bypass=1 sampled at the first input handshake of a block, the whole block SHALL be emitted with D=0 (out_line=buf[rd_idx]).
REQ-026 Without THETA_BYPASS_EN, the bypass port SHALL not exist and theta mixing SHALL always apply.

Verification
REQ-027 All-zero block, out_ready=1 -> 64 outputs all 0x0000000, out_last only on 64th, in_ready returns next cycle.
REQ-028 Slice 0 = 0x0000001, others 0 -> out slice 0 = 0x0210843, slice 1 = 0x1084210, all others 0.
REQ-029 Slice 63 = 0x0000001, others 0 -> slice 63 = 0x0210843, slice 0 = 0x1084210 (z wrap).
REQ-030 Slice 5 = 0x0000021 (even column parity), others 0 -> slice 5 out = 0x0000021, all others 0.
REQ-031 out_ready=0 for 3 cycles at rd_idx=10 -> out_line stable, slice 10 emitted exactly once, 64 total outputs.
REQ-032 rst pulse at rd_idx=20 -> next cycle out_valid=0, in_ready=1; fresh block of REQ-028 then yields exact REQ-028 response.
